// File: rtl/cpu_pkg.sv
// Shared core definitions: instruction width, opcode constants and the
// fetch FSM state type used by the instruction fetch unit.
package cpu_pkg;

   localparam int IR_W = 16;

   localparam logic [7:0] OP_INAC = 8'd2;
   localparam logic [7:0] OP_LOAD = 8'd5;
   localparam logic [7:0] OP_MVAC = 8'd7;
   localparam logic [7:0] OP_NOP  = 8'd8;

   // Opcode sits in the upper byte, operand in the lower byte.
   function automatic logic [IR_W-1:0] make_instr(input logic [7:0] op, input logic [7:0] arg);
      return {op, arg};
   endfunction

   localparam logic [IR_W-1:0] NOP_INSTR = 16'h0800;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Down-counting REQ watchdog for the fetch unit; expire asserts on the
// TIMEOUT_CYC-th counted cycle. Only instantiated under FETCH_TIMEOUT_EN.
module fetch_timeout_ctr #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= CW'(TIMEOUT_CYC - 1);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the req/ack read to instruction
// memory and latches the returned word into ir. Optional FETCH_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no fetch in flight, waiting for imr
//   REQ   | im_req high, im_addr held, waiting for im_ack (or timeout)
//   DONE  | ir just updated, fetch_done pulse; imr here chains a new fetch
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int             AW          = 8,
   parameter logic [AW-1:0]  RESET_PC    = '0,
   parameter int             TIMEOUT_CYC = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            imr,
   input  logic            pc_inc,
   input  logic            pcw,
   input  logic [AW-1:0]   pc_load_val,
   input  logic            finish,
   output logic            im_req,
   output logic [AW-1:0]   im_addr,
   input  logic            im_ack,
   input  logic [IR_W-1:0] im_rdata,
   output logic [IR_W-1:0] ir,
   output logic [AW-1:0]   pc,
   output logic            fetch_done,
   output logic            fetch_busy,
   output logic            fetch_err
);

   fetch_state_t state, state_nxt;

   logic halted;
   logic frozen;
   logic start;
   logic take_addr;
   logic load_ir;
   logic load_nop;
   logic timeout;

   // finish is latched so the unit stays halted until rst, even if the strobe drops
   assign frozen    = finish | halted;
   assign start     = imr & ~frozen;
   assign take_addr = start && (state != REQ);

   always_comb begin
      state_nxt = state;
      load_ir   = 1'b0;
      load_nop  = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = REQ;
         end
         REQ: begin
            if (im_ack) begin
               load_ir   = 1'b1;
               state_nxt = DONE;
            end else if (timeout) begin
               load_nop  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = start ? REQ : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         im_addr <= '0;
         ir      <= '0;
         halted  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (finish) halted <= 1'b1;
         if (!frozen) begin
            if (pcw)         pc <= pc_load_val;
            else if (pc_inc) pc <= pc + 1'b1;
         end
         if (take_addr) im_addr <= pc;
         if (load_ir)       ir <= im_rdata;
         else if (load_nop) ir <= NOP_INSTR;
      end
   end

   assign im_req     = (state == REQ);
   assign fetch_busy = (state == REQ);
   assign fetch_done = (state == DONE);

`ifdef FETCH_TIMEOUT_EN
   fetch_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (take_addr),
      .en     ((state == REQ) && !im_ack),
      .expire (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           fetch_err <= 1'b0;
      else if (load_nop) fetch_err <= 1'b1;
   end
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetches checked against a word-addressed memory and arithmetic PC model.
module tb_instr_fetch_unit;
   import cpu_pkg::*;

   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            rst, imr, pc_inc, pcw, finish, im_ack;
   logic [AW-1:0]   pc_load_val;
   logic [15:0]     im_rdata;
   logic            im_req, fetch_done, fetch_busy, fetch_err;
   logic [AW-1:0]   im_addr, pc;
   logic [15:0]     ir;

   logic [15:0]     mem [256];
   int              n_checks = 0;
   int              n_fail   = 0;
   int              mpc;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .imr         (imr),
      .pc_inc      (pc_inc),
      .pcw         (pcw),
      .pc_load_val (pc_load_val),
      .finish      (finish),
      .im_req      (im_req),
      .im_addr     (im_addr),
      .im_ack      (im_ack),
      .im_rdata    (im_rdata),
      .ir          (ir),
      .pc          (pc),
      .fetch_done  (fetch_done),
      .fetch_busy  (fetch_busy),
      .fetch_err   (fetch_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: pulse imr, ack on the n-th cycle im_req is seen,
   // return data from mem[] at the address the DUT requested.
   task automatic run_fetch(input int n, input bit inc, output logic [AW-1:0] addr,
                            output int req_seen, output int wait_cyc, output bit done_ok);
      addr = '0; req_seen = 0; wait_cyc = 0; done_ok = 1'b0;
      imr = 1'b1;
      tick();
      imr = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (im_req) begin
            req_seen++;
            if (req_seen == 1) addr = im_addr;
            if (req_seen == n) begin
               im_ack = 1'b1; im_rdata = mem[im_addr]; pc_inc = inc;
               tick();
               im_ack = 1'b0; pc_inc = 1'b0;
               done_ok = fetch_done;
               return;
            end
         end else if (req_seen == 0) begin
            wait_cyc++;
         end else begin
            done_ok = fetch_done;
            return;
         end
         tick();
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      mpc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0; imr = 0; pc_inc = 0; pcw = 0; finish = 0; im_ack = 0;
      pc_load_val = '0; im_rdata = '0;
      #1 rst = 1'b1;
      #2;
      n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
      n_checks++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", ir); end
      n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL reset_im_req got %b want 0", im_req); end
      n_checks++; if (im_addr !== 8'h00) begin n_fail++; $display("FAIL reset_im_addr got %h want 00", im_addr); end
      n_checks++; if (fetch_done !== 1'b0 || fetch_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags got done=%b busy=%b want 0 0", fetch_done, fetch_busy); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", fetch_err); end
      tick(); tick();
      @(negedge clk); rst = 1'b0;
      mpc = 0;
      tick();
      n_checks++; if (im_req !== 1'b0 || pc !== 8'h00) begin
         n_fail++; $display("FAIL post_reset_idle got req=%b pc=%h want 0 00", im_req, pc); end
   endtask

   task automatic test_single_fetch();
      logic [AW-1:0] a; int rs, wc; bit dn;
      mem[0] = 16'h0505;
      run_fetch(3, 1'b1, a, rs, wc, dn);
      mpc = (mpc + 1) % 256;
      n_checks++; if (a !== 8'h00) begin n_fail++; $display("FAIL single_addr got %h want 00", a); end
      n_checks++; if (wc !== 0 || rs !== 3) begin
         n_fail++; $display("FAIL single_req_timing got wait=%0d req=%0d want 0 3", wc, rs); end
      n_checks++; if (ir !== 16'h0505 || dn !== 1'b1) begin
         n_fail++; $display("FAIL single_ir got %h done=%b want 0505 1", ir, dn); end
      n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop got %b want 0", im_req); end
      tick();
      n_checks++; if (fetch_done !== 1'b0 || fetch_busy !== 1'b0) begin
         n_fail++; $display("FAIL single_done_pulse got done=%b busy=%b want 0 0", fetch_done, fetch_busy); end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a; int rs, wc; bit dn;
      pulse_reset();
      mem[0] = 16'h0505; mem[1] = 16'h0209;
      run_fetch(2, 1'b1, a, rs, wc, dn);
      mpc = (mpc + 1) % 256;
      n_checks++; if (ir !== 16'h0505 || dn !== 1'b1) begin
         n_fail++; $display("FAIL b2b_first got %h done=%b want 0505 1", ir, dn); end
      run_fetch(1, 1'b0, a, rs, wc, dn);
      n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL b2b_latency got wait=%0d want 0", wc); end
      n_checks++; if (a !== 8'h01) begin n_fail++; $display("FAIL b2b_addr got %h want 01", a); end
      n_checks++; if (ir !== 16'h0209 || dn !== 1'b1 || rs !== 1) begin
         n_fail++; $display("FAIL b2b_second got %h done=%b req=%0d want 0209 1 1", ir, dn, rs); end
      tick();
   endtask

   task automatic test_jump();
      pcw = 1'b1; pc_load_val = 8'hFF; tick(); pcw = 1'b0;
      n_checks++; if (pc !== 8'hFF) begin n_fail++; $display("FAIL jump_load got %h want ff", pc); end
      pc_inc = 1'b1; tick(); pc_inc = 1'b0;
      n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL jump_wrap got %h want 00", pc); end
      pcw = 1'b1; pc_inc = 1'b1; pc_load_val = 8'h10; tick(); pcw = 1'b0; pc_inc = 1'b0;
      n_checks++; if (pc !== 8'h10) begin n_fail++; $display("FAIL jump_priority got %h want 10", pc); end
      pcw = 1'b1; pc_load_val = 8'h03; tick(); pcw = 1'b0;
      imr = 1'b1; tick(); imr = 1'b0;
      n_checks++; if (im_req !== 1'b1 || im_addr !== 8'h03) begin
         n_fail++; $display("FAIL jump_req got req=%b addr=%h want 1 03", im_req, im_addr); end
      pcw = 1'b1; pc_load_val = 8'h40; tick(); pcw = 1'b0;
      n_checks++; if (im_addr !== 8'h03 || pc !== 8'h40) begin
         n_fail++; $display("FAIL jump_inflight got addr=%h pc=%h want 03 40", im_addr, pc); end
      im_ack = 1'b1; im_rdata = mem[3]; tick(); im_ack = 1'b0;
      n_checks++; if (ir !== mem[3] || fetch_done !== 1'b1) begin
         n_fail++; $display("FAIL jump_data got %h done=%b want %h 1", ir, fetch_done, mem[3]); end
      mpc = 8'h40;
      tick();
   endtask

   task automatic test_reset_mid_fetch();
      imr = 1'b1; tick(); imr = 1'b0;
      n_checks++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_up got %b want 1", im_req); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (im_req !== 1'b0 || fetch_busy !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_req_drop got req=%b busy=%b want 0 0", im_req, fetch_busy); end
      @(negedge clk); rst = 1'b0; mpc = 0;
      im_ack = 1'b1; im_rdata = 16'hBEEF; tick(); im_ack = 1'b0;
      n_checks++; if (ir !== 16'h0000 || fetch_done !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_late_ack got ir=%h done=%b want 0000 0", ir, fetch_done); end
      n_checks++; if (pc !== 8'h00 || im_req !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_state got pc=%h req=%b want 00 0", pc, im_req); end
   endtask

   task automatic test_random();
      logic [AW-1:0] a; int rs, wc, n, op, k; bit dn, inc, b2b;
      for (int i = 0; i < 24; i++) begin
         b2b = (i > 0) && ($urandom % 3 == 0);
         if (!b2b) begin
            tick();
            op = $urandom % 3;
            if (op == 1) begin
               pcw = 1'b1; pc_load_val = AW'($urandom); tick(); pcw = 1'b0;
               mpc = pc_load_val;
            end else if (op == 2) begin
               k = $urandom_range(1, 3);
               pc_inc = 1'b1;
               for (int j = 0; j < k; j++) tick();
               pc_inc = 1'b0;
               mpc = (mpc + k) % 256;
            end
         end
         n = $urandom_range(1, 4);
         inc = $urandom % 2;
         run_fetch(n, inc, a, rs, wc, dn);
         n_checks++; if (a !== AW'(mpc)) begin n_fail++; $display("FAIL rand_addr[%0d] got %h want %h", i, a, mpc); end
         n_checks++; if (rs !== n || wc !== 0) begin
            n_fail++; $display("FAIL rand_timing[%0d] got req=%0d wait=%0d want %0d 0", i, rs, wc, n); end
         n_checks++; if (ir !== mem[mpc] || dn !== 1'b1) begin
            n_fail++; $display("FAIL rand_ir[%0d] got %h done=%b want %h 1", i, ir, dn, mem[mpc]); end
         if (inc) mpc = (mpc + 1) % 256;
         n_checks++; if (pc !== AW'(mpc)) begin n_fail++; $display("FAIL rand_pc[%0d] got %h want %h", i, pc, mpc); end
      end
      tick();
   endtask

   task automatic test_finish();
      int reqs;
      imr = 1'b1; tick(); imr = 1'b0;
      finish = 1'b1; pc_inc = 1'b1; tick(); finish = 1'b0; pc_inc = 1'b0;
      im_ack = 1'b1; im_rdata = mem[mpc]; tick(); im_ack = 1'b0;
      n_checks++; if (ir !== mem[mpc] || fetch_done !== 1'b1) begin
         n_fail++; $display("FAIL finish_inflight got %h done=%b want %h 1", ir, fetch_done, mem[mpc]); end
      n_checks++; if (pc !== AW'(mpc)) begin n_fail++; $display("FAIL finish_pc_frozen got %h want %h", pc, mpc); end
      reqs = 0;
      for (int j = 0; j < 4; j++) begin
         imr = 1'b1; pc_inc = 1'b1; tick(); imr = 1'b0; pc_inc = 1'b0;
         if (im_req) reqs++;
         tick();
         if (im_req) reqs++;
      end
      n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL finish_no_req got %0d requests want 0", reqs); end
      n_checks++; if (pc !== AW'(mpc)) begin n_fail++; $display("FAIL finish_pc_hold got %h want %h", pc, mpc); end
      pulse_reset();
      imr = 1'b1; tick(); imr = 1'b0;
      n_checks++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL finish_release got %b want 1", im_req); end
      im_ack = 1'b1; im_rdata = mem[0]; tick(); im_ack = 1'b0; tick();
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      logic [AW-1:0] a; int rs, wc; bit dn;
      pulse_reset();
      run_fetch(99, 1'b0, a, rs, wc, dn);
      n_checks++; if (rs !== 16) begin n_fail++; $display("FAIL to_req_cycles got %0d want 16", rs); end
      n_checks++; if (ir !== 16'h0800 || dn !== 1'b1 || fetch_err !== 1'b1) begin
         n_fail++; $display("FAIL to_nop got ir=%h done=%b err=%b want 0800 1 1", ir, dn, fetch_err); end
      tick();
      run_fetch(2, 1'b0, a, rs, wc, dn);
      n_checks++; if (ir !== mem[0] || fetch_err !== 1'b1) begin
         n_fail++; $display("FAIL to_sticky got ir=%h err=%b want %h 1", ir, fetch_err, mem[0]); end
      pulse_reset();
      run_fetch(16, 1'b0, a, rs, wc, dn);
      n_checks++; if (ir !== mem[0] || fetch_err !== 1'b0 || dn !== 1'b1) begin
         n_fail++; $display("FAIL to_ack_wins got ir=%h err=%b done=%b want %h 0 1", ir, fetch_err, dn, mem[0]); end
      tick();
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_jump();
      test_reset_mid_fetch();
      test_random();
      test_finish();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`else
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL err_tied got %b want 0", fetch_err); end
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of State_machine in each core.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake.
- Latches the returned word into the 16-bit ir that drives State_machine's ir input.
- Sequencing strobes (imr, pc_inc, pcw, finish) come from State_machine; no decode is done here.

Parameters:
- AW, 8, instruction address width (PC width).
- RESET_PC, 0, PC value after reset.
- TIMEOUT_CYC, 16, max cycles im_req may stay high without im_ack (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imr  in  1  fetch request strobe from State_machine.
- pc_inc  in  1  increment PC.
- pcw  in  1  load PC from pc_load_val.
- pc_load_val  in  AW  jump target.
- finish  in  1  halt: freeze the unit.
- im_req  out  1  memory read request.
- im_addr  out  AW  memory word address.
- im_ack  in  1  read data valid this cycle.
- im_rdata  in  16  instruction word.
- ir  out  16  instruction register, to State_machine.
- pc  out  AW  current PC.
- fetch_done  out  1  one-cycle pulse when ir is updated.
- fetch_busy  out  1  high while the FSM is in REQ.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset: clk and one asynchronous, active-high reset (rst). While rst=1, all outputs clear immediately regardless of clk: pc=RESET_PC, ir=16'h0000, im_req=0, im_addr=0, fetch_done=0, fetch_busy=0, fetch_err=0, FSM=IDLE.
- FSM states: IDLE, REQ, DONE.
  - IDLE: imr=1 and finish=0 -> REQ. Capture im_addr<=pc on the same edge; im_req=1 from the next cycle.
  - REQ: im_req=1 and im_addr held stable. On im_ack=1: ir<=im_rdata, im_req drops on that edge, -> DONE.
  - DONE: fetch_done=1 for exactly this cycle. imr=1 and finish=0 here -> REQ (back-to-back fetch); otherwise -> IDLE.
- Latency: imr at edge N -> im_req visible cycle N+1; im_ack at edge M -> ir valid and fetch_done=1 in cycle M+1. Minimum is 2 cycles, imr to fetch_done.
- imr in REQ is ignored; no queueing.
- im_ack outside REQ is ignored; ir is unchanged.
- PC update, evaluated every edge in any state:
  - pcw has priority over pc_inc.
  - pc_inc gives pc+1 modulo 2^AW; 2^AW-1 wraps to 0.
  - A PC change during REQ does not alter im_addr; the in-flight fetch completes at the old address.
- finish=1: PC frozen and new imr ignored. An in-flight REQ still completes to DONE, then FSM stays IDLE. Release occurs only via rst.
- fetch_busy = (state==REQ).
- Reset asserted during REQ drops im_req immediately (async). A late im_ack after rst deasserts is ignored because the FSM is in IDLE.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - Counter clears on entering REQ and increments each REQ cycle without im_ack.
  - If the count reaches TIMEOUT_CYC: im_req drops, ir<=NOP_INSTR (16'h0800), fetch_err<=1 (sticky until rst), -> DONE with the normal fetch_done pulse.
  - im_ack arriving on the timeout cycle wins: normal load, no error.
- FETCH_TIMEOUT_EN undefined: REQ waits indefinitely; fetch_err tied 0; no counter logic.

Decomposition:
- Shared package cpu_pkg:
  - IR_W=16 and opcode constants (LOAD=5, INAC=2, MVAC=7, NOP=8, ...).
  - NOP_INSTR=16'h0800.
  - fetch_state_t enum {IDLE, REQ, DONE}.
- One sub-module, fetch_timeout_ctr (count/clear/expire), instantiated only under FETCH_TIMEOUT_EN.
- PC and FSM remain in the top module.

Test Plan:
1. Reset then single fetch: rst pulse; memory returns 16'h0505 at addr 0 with 3-cycle ack delay; imr pulse -> im_addr=0, im_req high 3 cycles, ir=16'h0505, fetch_done one cycle, fetch_busy low after.
2. Back-to-back with increment: pc_inc with fetch_done, imr in DONE; mem[1]=16'h0209 with 0-wait ack -> second im_req the cycle after DONE at im_addr=1, ir=16'h0209.
3. Jump priority and wrap: pc=8'hFF, pc_inc -> pc=0. Then pcw=1 and pc_inc=1 with pc_load_val=8'h10 -> pc=8'h10, not 8'h11. pcw during REQ at addr 3 -> im_addr stays 3.
4. Reset mid-fetch: assert rst between clk edges while im_req=1 -> im_req=0 immediately; ack after release ignored; ir=0.
5. Finish: finish=1 during REQ -> fetch completes and ir updates; subsequent imr pulses produce no im_req; pc_inc has no effect.
6. FETCH_TIMEOUT_EN: never ack -> im_req drops after 16 cycles, ir=16'h0800, fetch_err=1 and remains set across later successful fetches. Ack exactly on cycle 16 -> data loaded, fetch_err=0.
